// File: rtl/h_gate_scheduler.sv
// Round-robin issue scheduler for one shared H datapath; 5-cycle accept-to-result latency.
// Ready is gated only by reset, flush and request presence; results never backpressure.
module h_gate_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int H_LAT       = 3,
    parameter int TOTAL_WIDTH = 4,
    parameter int TAG_W       = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
    parameter int OPW         = 4 * TOTAL_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*OPW-1:0]   req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     h_rst_n,
    output logic [OPW-1:0]           h_op,
    input  logic [OPW-1:0]           h_res,
    output logic                     res_valid,
    output logic [TAG_W-1:0]         res_tag,
    output logic [OPW-1:0]           res_data,
    output logic                     idle
);

    localparam int DL = 1 + H_LAT;

    logic [TAG_W-1:0]     ptr;
    logic [TAG_W-1:0]     ptr_nxt;
    logic [TAG_W-1:0]     gidx;
    logic                 found;
    logic                 accept;
    logic [2*NUM_REQ-1:0] dbl;
    logic [2*NUM_REQ-1:0] rot;
    logic [TAG_W:0]       gsum;
    logic [TAG_W:0]       nsum;

    logic [DL-1:0]        dl_vld;
    logic [TAG_W-1:0]     dl_tag [DL];

    assign h_rst_n = ~rst;

    // Rotate the request vector so bit 0 is the requester at the pointer.
    always_comb begin
        dbl   = {req_valid, req_valid};
        rot   = dbl >> ptr;
        found = 1'b0;
        gsum  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                gsum  = {1'b0, ptr} + (TAG_W+1)'(k);
            end
        end
        if (gsum >= (TAG_W+1)'(NUM_REQ)) begin
            gsum = gsum - (TAG_W+1)'(NUM_REQ);
        end
        gidx = gsum[TAG_W-1:0];

        nsum = {1'b0, gidx} + (TAG_W+1)'(1);
        if (nsum >= (TAG_W+1)'(NUM_REQ)) begin
            nsum = '0;
        end
        ptr_nxt = nsum[TAG_W-1:0];
    end

    always_comb begin
        req_ready = '0;
        if (found && !flush && !rst) begin
            req_ready = NUM_REQ'(1) << gidx;
        end
    end

    assign accept = |(req_valid & req_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr  <= '0;
            h_op <= '0;
        end else if (accept) begin
            ptr  <= ptr_nxt;
            h_op <= req_data[gidx*OPW +: OPW];
        end
    end

    // Tags shift even during flush; the cleared valids make them don't-care.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_vld    <= '0;
            res_valid <= 1'b0;
            res_tag   <= '0;
            res_data  <= '0;
            for (int i = 0; i < DL; i++) begin
                dl_tag[i] <= '0;
            end
        end else begin
            if (flush) begin
                dl_vld    <= '0;
                res_valid <= 1'b0;
            end else begin
                dl_vld    <= {dl_vld[DL-2:0], accept};
                res_valid <= dl_vld[DL-1];
            end
            dl_tag[0] <= gidx;
            for (int i = 1; i < DL; i++) begin
                dl_tag[i] <= dl_tag[i-1];
            end
            res_tag  <= dl_tag[DL-1];
            res_data <= h_res;
        end
    end

    assign idle = ~(|dl_vld | res_valid);

endmodule

// File: doc/h_gate_scheduler.md
# h_gate_scheduler

Round-robin issue scheduler that shares one pipelined Hadamard datapath (3 register stages, S1.2 operands, `TOTAL_WIDTH`=4, `FRAC_WIDTH`=2) between `NUM_REQ` qubit-lane requesters. It accepts at most one operand set per cycle through a valid/ready handshake and registers it into the datapath inputs. It tracks each in-flight operation with a valid/tag delay line matched to the datapath latency, then returns the registered result tagged with the originating requester. It sits between the per-lane QFT stage controllers and the shared H unit.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `H_LAT`, 3: H datapath register stages. Fixed by the H unit; must not be overridden.
- `TAG_W`, max(1, clog2(`NUM_REQ`)): result tag width.
- `OPW`, 4*`TOTAL_WIDTH` = 16: packed operand/result width; field order MSB→LSB is alpha_r, alpha_i, beta_r, beta_i.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous; discards all in-flight operations.
- `req_valid` in `NUM_REQ`: per-requester operand valid.
- `req_data` in `NUM_REQ`*`OPW`: requester i occupies bits [i*OPW +: OPW].
- `req_ready` out `NUM_REQ`: one-hot or zero; indicates the grant.
- `h_rst_n` out 1: equals ~`rst` (combinational); drives the H unit reset.
- `h_op` out `OPW`: registered operands to the H unit.
- `h_res` in `OPW`: H unit outputs {new_alpha_r, new_alpha_i, new_beta_r, new_beta_i}.
- `res_valid` out 1: result valid, one cycle per operation.
- `res_tag` out `TAG_W`: originating requester index.
- `res_data` out `OPW`: registered copy of `h_res`.
- `idle` out 1: high when no operation is in flight.

## Operation
- **Reset values.** `req_ready`=0, `h_op`=0, `res_valid`=0, `res_tag`=0, `res_data`=0, `idle`=1. The RR pointer resets to 0 and every delay-line valid bit resets to 0.
- **Arbitration** (combinational):
  - Search `req_valid` starting at the pointer, wrapping modulo `NUM_REQ`.
  - The first asserted requester g gets `req_ready[g]`=1.
  - `req_ready` is all-zero when `flush`=1, when `rst`=1, or when no request is pending.
- **Ready is not conditioned on downstream space.** The H unit never stalls and results have no backpressure, so the only blocking conditions are the three listed above.
- **Accept** means `req_valid[g]` & `req_ready[g]` at a rising edge. On accept:
  - `h_op` ← requester g's slice.
  - The delay-line head loads valid=1, tag=g.
  - The pointer ← (g+1) mod `NUM_REQ`.
- **No accept.** `h_op` holds its value, the head valid loads 0, and the pointer holds.
- **Delay line.** Valid/tag stages number 1 + `H_LAT` = 4 and shift every cycle. The output register captures stage 4: `res_valid` ← stage valid, `res_tag` ← stage tag, and `res_data` ← `h_res` (unconditional load; meaningful only when valid).
- **Flush.** All delay-line valid bits and `res_valid` clear at the edge; accept is blocked that cycle. The pointer and `h_op` hold. The H unit itself is not reset; its stale outputs are ignored because their valids were cleared.
- **Idle.** `idle` = NOR of all delay-line valid bits and `res_valid`.
- **No arithmetic.** The scheduler does none; data passes through bit-exact.
- **Reset mid-operation.** All in-flight operations are lost; no `res_valid` is produced for them after reset release.

## Timing
- Handshake in cycle c gives `h_op` valid in c+1, H outputs valid in c+4, and `res_valid`/`res_data`/`res_tag` in cycle c+5. Latency is 5 cycles and fixed.
- Throughput is one accept per cycle. Back-to-back accepts produce results on consecutive cycles in accept order.
- A requester holding `req_valid` with all others idle is granted every cycle.
- With k requesters continuously valid, each is granted once every k cycles.
- `req_data` is sampled only on the accepting edge. A requester may change data after its accept.
- `flush` in cycle f: no `res_valid` in cycles f+1..f+5 for operations accepted at or before f. A request accepted in f+1 returns normally in f+6.

## Test plan
- **Reset.** Assert `rst` with `req_valid`=4'b1111 → `req_ready`=0, `res_valid`=0, `idle`=1, `h_rst_n`=0. Release → requester 0 is granted first.
- **Single op.** Requester 2 sends alpha=(4,0), beta=(0,0) in cycle c → `res_valid` in c+5 only, with `res_tag`=2 and `res_data`={3,0,3,0}.
- **Fairness.** All four requesters held valid for 8 cycles → grant sequence 0,1,2,3,0,1,2,3. Results return tagged in the same order on 8 consecutive cycles, starting 5 cycles after the first accept.
- **Wrap-around.** Pointer at 3 with only requesters 1 and 3 valid → grant 3, then 1, then 3.
- **Flush.** Three accepts in c..c+2 and `flush` in c+3 → no `res_valid` in c+4..c+8. `req_ready`=0 in c+3. `idle`=1 from c+4.
- **Reset mid-stream.** Pulse `rst` two cycles after an accept → that result is never emitted, and outputs take their reset values immediately (asynchronously).
